seq_restoring_divider: RTL and testbench



---
 rtl/seq_restoring_divider.sv | 201 ++++++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
//   Multi-cycle unsigned restoring divider. Each RUN cycle performs one
//   trial subtraction through a single ripple_borrow_subtractor at width
//   WIDTH+1. It produces one quotient bit per cycle and restores the
//   partial remainder whenever the trial subtraction borrows.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     operands present
//   in_ready     divider idle and able to accept operands
//   dividend     unsigned dividend, WIDTH bits
//   divisor      unsigned divisor, WIDTH bits
//   out_valid    result present
//   out_ready    consumer accepts result
//   quotient     unsigned quotient, WIDTH bits
//   remainder    unsigned remainder, WIDTH bits
//   div_by_zero  result came from a zero divisor
//
// ripple_borrow_subtractor (same file)
//   Combinational a - b - bin with a rippled borrow chain.
//   s is the difference. cout is the borrow out of the top bit.

module ripple_borrow_subtractor #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH:0] borrow;

    // Bit-serial borrow chain. A bit borrows when a < b + borrow_in at that position.
    always_comb begin
        borrow    = '0;
        s         = '0;
        borrow[0] = bin;
        for (int i = 0; i < WIDTH; i++) begin
            s[i]        = a[i] ^ b[i] ^ borrow[i];
            borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
        end
        cout = borrow[WIDTH];
    end

endmodule

module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_b;
    logic [WIDTH:0]   trial_s;
    logic             trial_borrow;
    logic             trial_msb_unused;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    // Shift the next dividend bit into the partial remainder and try to subtract D.
    assign trial_a = {r_q, q_q[WIDTH-1]};
    assign trial_b = {1'b0, d_q};

    ripple_borrow_subtractor #(.WIDTH(WIDTH + 1)) u_trial_sub (
        .a    (trial_a),
        .b    (trial_b),
        .bin  (1'b0),
        .s    (trial_s),
        .cout (trial_borrow)
    );

    // The top difference bit carries no information when there is no borrow,
    // because the remainder is always below D.
    assign trial_msb_unused = trial_s[WIDTH];

    // Restoring step. On a borrow, keep the shifted remainder and record a 0.
    // Otherwise, take the difference and record a 1.
    always_comb begin
        if (trial_borrow) begin
            r_next = trial_a[WIDTH-1:0];
            q_next = {q_q[WIDTH-2:0], 1'b0};
        end else begin
            r_next = trial_s[WIDTH-1:0];
            q_next = {q_q[WIDTH-2:0], 1'b1};
        end
    end

    // Next-state and handshake logic. Every register holds unless its state says otherwise.
    always_comb begin
        state_d       = state_q;
        q_d           = q_q;
        d_d           = d_q;
        r_d           = r_q;
        cnt_d         = cnt_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        in_ready      = 1'b0;
        out_valid     = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    q_d = dividend;
                    d_d = divisor;
                    r_d = '0;
                    if (divisor == '0) begin
                        quotient_d    = '1;
                        remainder_d   = dividend;
                        div_by_zero_d = 1'b1;
                        state_d       = DONE;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                q_d = q_next;
                r_d = r_next;
                if (cnt_q == '0) begin
                    quotient_d    = q_next;
                    remainder_d   = r_next;
                    div_by_zero_d = 1'b0;
                    state_d       = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            q_q           <= '0;
            d_q           <= '0;
            r_q           <= '0;
            cnt_q         <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            q_q           <= q_d;
            d_q           <= d_d;
            r_q           <= r_d;
            cnt_q         <= cnt_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider
//   Scoreboard bench for seq_restoring_divider at WIDTH=8. The stimulus
//   tasks push the expected result when the divider accepts operands.
//   A negedge monitor pops and compares whenever a result handshake occurs.

module tb_seq_restoring_divider;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           driveCycle;
        int           expLat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    bit   randMode = 1'b0;
    bit   seen     = 1'b0;
    exp_t sb[$];

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // 10-unit clock and a free-running cycle count used for latency measurement.
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Random consumer stalls, applied well after the edge so the monitor sees settled values.
    always @(posedge clk) begin
        #2;
        if (randMode) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Backstop against a hung design.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
        int   waitCnt = 0;
        exp_t item;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        while (!in_ready && waitCnt < 300) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        item.q          = eq;
        item.r          = er;
        item.dbz        = edbz;
        item.driveCycle = cycle;
        item.expLat     = (b == '0) ? 1 : W + 1;
        sb.push_back(item);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", sb.size(), 0);
    endtask

    // Monitor: checks latency on the first sight of each result and compares values on the handshake.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (sb.size() == 0) checkOutput("spurious_result", 1, 0);
                else checkOutput("latency", cycle - sb[0].driveCycle, sb[0].expLat);
            end
            if (out_ready) begin
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("quotient", quotient, e.q);
                    checkOutput("remainder", remainder, e.r);
                    checkOutput("div_by_zero", div_by_zero, e.dbz);
                end
                seen = 1'b0;
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_quotient", quotient, 0);
        checkOutput("reset_remainder", remainder, 0);
        checkOutput("reset_dbz", div_by_zero, 0);
        rst = 1'b0;

        $display("[TB] directed vectors");
        applyStimulus(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        applyStimulus(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        applyStimulus(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
        applyStimulus(8'd37, 8'd0, 8'd255, 8'd37, 1'b1);
        waitDrain();

        $display("[TB] backpressure");
        @(posedge clk);
        #1 out_ready = 1'b0;
        applyStimulus(8'd200, 8'd13, 8'd15, 8'd5, 1'b0);
        begin
            int n = 0;
            @(negedge clk);
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            checkOutput("bp_out_valid", out_valid, 1);
        end
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_hold_quotient", quotient, 15);
            checkOutput("bp_hold_remainder", remainder, 5);
            checkOutput("bp_in_ready_low", in_ready, 0);
            checkOutput("bp_out_valid_held", out_valid, 1);
            if (i == 1) begin
                dividend = 8'd1;
                divisor  = 8'd1;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_in_ready_after", in_ready, 1);
        checkOutput("bp_out_valid_after", out_valid, 0);
        checkOutput("bp_queue_empty", sb.size(), 0);

        $display("[TB] reset mid-operation");
        applyStimulus(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_in_ready", in_ready, 1);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_quotient", quotient, 0);
        checkOutput("midrst_remainder", remainder, 0);
        sb.delete();
        seen = 1'b0;
        rst  = 1'b0;
        applyStimulus(8'd9, 8'd3, 8'd3, 8'd0, 1'b0);
        waitDrain();

        $display("[TB] randomized sweep");
        randMode = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            logic [W-1:0] a, b, eq, er;
            logic         edbz;
            int           kind;
            kind = $urandom_range(0, 9);
            a    = W'($urandom_range(0, 255));
            if (kind == 0) begin
                b = '0;
            end else if (kind <= 2) begin
                b = W'($urandom_range(1, 255));
                a = W'($urandom_range(0, int'(b) - 1));
            end else begin
                b = W'($urandom_range(1, 255));
            end
            if (b == '0) begin
                eq   = '1;
                er   = a;
                edbz = 1'b1;
            end else begin
                eq   = a / b;
                er   = a % b;
                edbz = 1'b0;
            end
            applyStimulus(a, b, eq, er, edbz);
        end
        waitDrain();
        randMode = 1'b0;
        @(posedge clk);
        #3 out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("final_idle", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
